serial_magnitude_cascade: RTL and testbench

//  Sits directly downstream of the 2-bit relative-magnitude detector.

---
 rtl/serial_magnitude_cascade.sv | 114 +++++++++++
 tb/tb_serial_magnitude_cascade.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_cascade.sv
// Cascades per-digit lt/eq/gt flags (MSB digit first) into one frame verdict.
// Verdict is held behind a valid/ready handshake until the consumer takes it.
module serial_magnitude_cascade #(
   parameter int MAX_DIGITS = 8,
   parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   input  logic             lt_in,
   input  logic             eq_in,
   input  logic             gt_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             res_lt,
   output logic             res_eq,
   output logic             res_gt,
   output logic [CNT_W-1:0] digit_count,
   output logic             err
);

   typedef enum logic {COLLECT, HOLD} state_t;

   state_t           state, state_n;
   logic             decided, decided_n;
   logic             dec_gt, dec_gt_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             err_r, err_r_n;
   logic             res_lt_n, res_eq_n, res_gt_n, err_n;
   logic [CNT_W-1:0] digit_count_n;
   logic             one_hot;
   logic             at_max;

   assign in_ready  = (state == COLLECT);
   assign out_valid = (state == HOLD);

   assign one_hot = (lt_in ^ eq_in ^ gt_in) & ~(lt_in & eq_in & gt_in);
   assign at_max  = (cnt == CNT_W'(MAX_DIGITS - 1));

   always_comb begin
      state_n       = state;
      decided_n     = decided;
      dec_gt_n      = dec_gt;
      cnt_n         = cnt;
      err_r_n       = err_r;
      res_lt_n      = res_lt;
      res_eq_n      = res_eq;
      res_gt_n      = res_gt;
      digit_count_n = digit_count;
      err_n         = err;
      unique case (state)
         COLLECT: begin
            if (in_valid) begin
               cnt_n = cnt + CNT_W'(1);
               // Illegal flag patterns count as an equal digit.
               if (!one_hot) begin
                  err_r_n = 1'b1;
               end else if (!decided && (gt_in || lt_in)) begin
                  decided_n = 1'b1;
                  dec_gt_n  = gt_in;
               end
               if (in_last || at_max) begin
                  if (!in_last) err_r_n = 1'b1;
                  state_n       = HOLD;
                  res_gt_n      = decided_n & dec_gt_n;
                  res_lt_n      = decided_n & ~dec_gt_n;
                  res_eq_n      = ~decided_n;
                  digit_count_n = cnt_n;
                  err_n         = err_r_n;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_n   = COLLECT;
               decided_n = 1'b0;
               dec_gt_n  = 1'b0;
               cnt_n     = '0;
               err_r_n   = 1'b0;
            end
         end
         default: state_n = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= COLLECT;
         decided     <= 1'b0;
         dec_gt      <= 1'b0;
         cnt         <= '0;
         err_r       <= 1'b0;
         res_lt      <= 1'b0;
         res_eq      <= 1'b0;
         res_gt      <= 1'b0;
         digit_count <= '0;
         err         <= 1'b0;
      end else begin
         state       <= state_n;
         decided     <= decided_n;
         dec_gt      <= dec_gt_n;
         cnt         <= cnt_n;
         err_r       <= err_r_n;
         res_lt      <= res_lt_n;
         res_eq      <= res_eq_n;
         res_gt      <= res_gt_n;
         digit_count <= digit_count_n;
         err         <= err_n;
      end
   end

endmodule

// File: tb/tb_serial_magnitude_cascade.sv
// Scoreboard bench: driver pushes expected verdicts, monitor pops on handshake.
// Reference model works on whole frames of digits, not on register updates.
module tb_serial_magnitude_cascade;

   localparam int MAXD = 4;
   localparam int CW   = $clog2(MAXD + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_last = 1'b0;
   logic          lt_in = 1'b0, eq_in = 1'b0, gt_in = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          res_lt, res_eq, res_gt;
   logic [CW-1:0] digit_count;
   logic          err;

   serial_magnitude_cascade #(.MAX_DIGITS(MAXD)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .lt_in(lt_in), .eq_in(eq_in), .gt_in(gt_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .res_lt(res_lt), .res_eq(res_eq), .res_gt(res_gt),
      .digit_count(digit_count), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          lt, eq, gt;
      logic [CW-1:0] n;
      logic          e;
   } verdict_t;

   localparam logic [2:0] D_LT = 3'b100;
   localparam logic [2:0] D_EQ = 3'b010;
   localparam logic [2:0] D_GT = 3'b001;

   verdict_t   exp_q[$];
   logic [2:0] frame[$];
   int tests = 0;
   int fails = 0;
   logic busy = 1'b0;

   task automatic check(string name, int act, int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Frame verdict: first strictly lt/gt digit decides; any bad digit or overrun flags err.
   function automatic verdict_t judge(logic overrun);
      verdict_t v;
      int dir = 0;
      logic bad = overrun;
      foreach (frame[i]) begin
         if (frame[i] != D_LT && frame[i] != D_EQ && frame[i] != D_GT) bad = 1'b1;
         else if (dir == 0 && frame[i] == D_GT) dir = 1;
         else if (dir == 0 && frame[i] == D_LT) dir = -1;
      end
      v.lt = (dir < 0);
      v.gt = (dir > 0);
      v.eq = (dir == 0);
      v.n  = CW'(frame.size());
      v.e  = bad;
      return v;
   endfunction

   task automatic send(logic [2:0] f, logic last);
      int waited = 0;
      {lt_in, eq_in, gt_in} = f;
      in_last  = last;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
         if (waited > 200) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      frame.push_back(f);
      if (last || frame.size() == MAXD) begin
         exp_q.push_back(judge(!last));
         frame.delete();
         check("latency_out_valid", int'(out_valid), 1);
         check("hold_in_ready", int'(in_ready), 0);
      end
   endtask

   always @(posedge clk) begin
      #1;
      out_ready <= busy ? 1'b0 : 1'($urandom_range(0, 1));
   end

   logic     pv = 1'b0, pr = 1'b0;
   verdict_t pout;

   always @(negedge clk) begin
      verdict_t cur, e;
      cur = '{res_lt, res_eq, res_gt, digit_count, err};
      if (!rst_n) begin
         pv = 1'b0;
      end else begin
         check("in_ready_vs_out_valid", int'(in_ready), int'(!out_valid));
         if (out_valid) check("one_hot_result", res_lt + res_eq + res_gt, 1);
         if (pv && !pr) begin
            check("stall_valid", int'(out_valid), 1);
            check("stall_stable", int'(cur), int'(pout));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_verdict", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("verdict_lt", int'(res_lt), int'(e.lt));
               check("verdict_eq", int'(res_eq), int'(e.eq));
               check("verdict_gt", int'(res_gt), int'(e.gt));
               check("verdict_count", int'(digit_count), int'(e.n));
               check("verdict_err", int'(err), int'(e.e));
            end
         end
         pv = out_valid;
         pr = out_ready;
         pout = cur;
      end
   end

   task automatic drain();
      int n = 0;
      busy = 1'b0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_res", int'({res_lt, res_eq, res_gt}), 0);
      check("rst_count", int'(digit_count), 0);
      check("rst_err", int'(err), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // A=0xB4 vs B=0xB1: digits eq,eq,gt,lt
      send(D_EQ, 0); send(D_EQ, 0); send(D_GT, 0); send(D_LT, 1);
      send(D_EQ, 0); send(D_EQ, 0); send(D_EQ, 0); send(D_EQ, 1);
      send(D_LT, 1);
      drain();

      busy = 1'b1;
      send(D_LT, 0); send(D_GT, 0); send(D_GT, 1);
      repeat (5) @(posedge clk);
      #1;
      check("stalled_out_valid", int'(out_valid), 1);
      check("stalled_in_ready", int'(in_ready), 0);
      drain();

      // Overrun: the 5th eq digit opens a new frame after the handshake
      send(D_EQ, 0); send(D_EQ, 0); send(D_EQ, 0); send(D_EQ, 0);
      send(D_EQ, 1);
      send(3'b011, 0); send(D_EQ, 1);
      send(D_GT, 0); send(D_EQ, 1);
      drain();

      send(D_GT, 0); send(D_GT, 0);
      rst_n = 1'b0;
      frame.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("reset_mid_no_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
      check("reset_mid_still_no_valid", int'(out_valid), 0);
      send(D_EQ, 0); send(D_EQ, 1);
      drain();

      for (int f = 0; f < 60; f++) begin
         int len = $urandom_range(1, MAXD + 2);
         for (int d = 0; d < len; d++) begin
            logic [2:0] fl;
            if ($urandom_range(0, 9) == 0) fl = 3'($urandom_range(0, 7));
            else fl = (d < 2 && $urandom_range(0, 1) == 1) ? D_EQ :
                      (3'b001 << $urandom_range(0, 2));
            send(fl, (d == len - 1) ? 1'b1 : 1'b0);
         end
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
